regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port register file. It is the next generation of the CPU integer register file, sitting between decode (reads and scoreboard) and write-back (two write ports: ALU and load).
- Adds a hardware clear sequence after reset, so register contents are defined zero, not X.
- Adds a dual write port with fixed priority, optional write-to-read bypass, and a pending-write scoreboard so decode can stall on RAW hazards.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero; writes to it are dropped, busy for it is always 0
BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees the stored value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
rd_en  in  1  read enable; 0 forces all rd_data to 0
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, combinational
busy  out  NUM_RD  1 = register at rd_addr[i] has a pending write
wr0_en  in  1  write port 0 enable (ALU)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load; higher priority)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
pend_set  in  1  mark pend_addr as having an outstanding producer
pend_addr  in  ADDR_W  destination being issued
ready  out  1  1 = clear sequence done, file usable

Behaviour:
- State machine: CLEAR, RUN.
- rst low (async): enter CLEAR, clear counter to 0, clear all pending bits, ready=0.
- Register array contents are not reset asynchronously; the clear sequence zeroes them.
- CLEAR, one entry per rising clk edge:
  - Writes zero to entry[counter], then counter increments.
  - After the write of entry DEPTH-1, go to RUN. This is the DEPTH-th edge after rst release.
  - ready rises after that edge, so ready=1 in the next cycle.
- During CLEAR:
  - wr0, wr1 and pend_set are ignored.
  - rd_data = 0 and busy = all ones, which stalls decode.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to CLEAR with counter = 0; the full sequence is restarted.
- RUN writes, committed on the rising edge:
  - wr0 and wr1 to different addresses: both commit.
  - Same address: wr1 data wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- RUN reads:
  - Combinational, zero latency.
  - rd_en=0 gives 0 on every port.
  - Address 0 with ZERO_REG=1 gives 0.
- Bypass (BYPASS=1): if wr1_en and wr1_addr==rd_addr[i], return wr1_data. Else if wr0_en and wr0_addr==rd_addr[i], return wr0_data. Else return the stored value. The address-0 rule takes precedence over bypass.
- Scoreboard, one pending bit per register:
  - pend_set sets bit[pend_addr] at the edge.
  - Any wr0/wr1 write clears the bit for its address at the edge.
  - Same-edge set and clear on the same address: set wins, because the newer producer is outstanding.
  - pend_set to address 0 with ZERO_REG=1 is ignored.
  - busy[i] = bit[rd_addr[i]], independent of rd_en.
  - busy does not include same-cycle bypass: a write landing this cycle still shows busy until the edge; decode stalls one cycle.
- Reset values: rd_data=0, busy=all ones, ready=0.

Test Plan:
- Reset/clear: DEPTH=32, release rst; ready=0 for 32 edges and 1 after the 32nd; then read r1..r31 -> all 0x00000000; busy=0 throughout RUN.
- Reset mid-clear: assert rst at counter=10 and release; ready is reasserted exactly 32 edges after release, not 22; wr0 to r5 during CLEAR does not land (r5 reads 0).
- Dual write collision: wr0 r7=0x11111111 and wr1 r7=0x22222222 on the same edge -> r7 reads 0x22222222. Write r0=0xDEADBEEF -> r0 reads 0.
- Bypass: BYPASS=1, r3 holds 0xAAAA0000, wr0 r3=0x12345678 this cycle -> rd_data port0 for r3 = 0x12345678 in the same cycle. With BYPASS=0 the same stimulus reads 0xAAAA0000 and then 0x12345678 next cycle.
- Scoreboard: pend_set r9 -> busy for r9 = 1 next cycle. wr1 r9 clears it after the edge. Same-edge pend_set r9 and wr0 r9 -> busy stays 1.
- Read disable: rd_en=0 with r4=0x5 -> rd_data=0 on all ports; busy still reflects r4's pending bit.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a post-reset clear sequence,
// two prioritised write ports, optional write-to-read bypass and a
// pending-write scoreboard for RAW stall detection in decode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing one entry per edge; writes/pend ignored, reads 0,
//         | busy all ones
// S_RUN   | normal operation; ready_o = 1
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          busy_o,
    input  logic                       wr0_en_i,
    input  logic [ADDR_W-1:0]          wr0_addr_i,
    input  logic [DATA_W-1:0]          wr0_data_i,
    input  logic                       wr1_en_i,
    input  logic [ADDR_W-1:0]          wr1_addr_i,
    input  logic [DATA_W-1:0]          wr1_data_i,
    input  logic                       pend_set_i,
    input  logic [ADDR_W-1:0]          pend_addr_i,
    output logic                       ready_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic                  ready_q;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;

    logic                  run;
    logic                  wr0_ok;
    logic                  wr1_ok;
    logic                  pend_ok;

    assign run     = (state_q == S_RUN);
    // Writes and issue marks to the hardwired zero register are dropped.
    assign wr0_ok  = run && wr0_en_i  && !((ZERO_REG != 0) && (wr0_addr_i  == '0));
    assign wr1_ok  = run && wr1_en_i  && !((ZERO_REG != 0) && (wr1_addr_i  == '0));
    assign pend_ok = run && pend_set_i && !((ZERO_REG != 0) && (pend_addr_i == '0));
    assign ready_o = ready_q;

    // Sequencer: walk the clear counter through every entry, then run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: cleared by the sequencer, not by reset; wr1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[wr0_addr_i] <= wr0_data_i;
            if (wr1_ok) mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    // Scoreboard next state: writes retire, a new issue to the same register takes precedence.
    always_comb begin
        pend_d = pend_q;
        if (run) begin
            if (wr0_en_i) pend_d[wr0_addr_i] = 1'b0;
            if (wr1_en_i) pend_d[wr1_addr_i] = 1'b0;
            if (pend_ok)  pend_d[pend_addr_i] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;
        logic              is_zero;

        assign ra      = rd_addr_i[g*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);

        // Read mux: zero-register rule beats bypass, wr1 bypass beats wr0.
        always_comb begin
            rdata = '0;
            if (run && rd_en_i && !is_zero) begin
                if ((BYPASS != 0) && wr1_en_i && (wr1_addr_i == ra))
                    rdata = wr1_data_i;
                else if ((BYPASS != 0) && wr0_en_i && (wr0_addr_i == ra))
                    rdata = wr0_data_i;
                else
                    rdata = mem_q[ra];
            end
        end

        // Busy ignores rd_en and same-cycle writes; everything is busy while clearing.
        always_comb begin
            rbusy = 1'b1;
            if (run) rbusy = is_zero ? 1'b0 : pend_q[ra];
        end

        assign rd_data_o[g*DATA_W +: DATA_W] = rdata;
        assign busy_o[g]                     = rbusy;
    end

endmodule
